// File: rtl/baud_pkg.sv
// Shared divisor type and standard 50 MHz / x16 oversample divisor constants.
package baud_pkg;

  localparam int unsigned BaudDivW  = 16;
  localparam int unsigned BaudFracW = 4;

  typedef struct packed {
    logic [BaudDivW-1:0]  div_int;
    logic [BaudFracW-1:0] div_frac;
  } baud_div_t;

  localparam baud_div_t Baud9600   = '{div_int: 16'd325, div_frac: 4'd8};
  localparam baud_div_t Baud19200  = '{div_int: 16'd162, div_frac: 4'd12};
  localparam baud_div_t Baud38400  = '{div_int: 16'd81,  div_frac: 4'd6};
  localparam baud_div_t Baud57600  = '{div_int: 16'd54,  div_frac: 4'd4};
  localparam baud_div_t Baud115200 = '{div_int: 16'd27,  div_frac: 4'd2};

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator: carry stretches the current period by one clk.
module baud_frac_acc
  import baud_pkg::*;
#(
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              step,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, frac};
    carry = sum[FRAC_W];
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (step) begin
      acc_d = sum[FRAC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-N baud generator: oversample and bit ticks with shadowed divisor
// updates that only take effect on period boundaries.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned FRAC_W       = 4,
  parameter int unsigned OSR          = 16,
  parameter int unsigned DEF_DIV_INT  = 27,
  parameter int unsigned DEF_DIV_FRAC = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [DIV_W-1:0]        div_int,
  input  logic [FRAC_W-1:0]       div_frac,
  input  logic                    load,
  input  logic                    sync_restart,
  input  logic                    align_mid,
  output logic                    os_tick,
  output logic                    bit_tick,
  output logic                    cfg_ack,
  output logic [DIV_W+FRAC_W-1:0] active_div
);

  localparam int unsigned OsW = $clog2(OSR);

  logic              en_q;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [OsW-1:0]    os_cnt_q, os_cnt_d;
  logic [DIV_W-1:0]  act_int_q, act_int_d, pend_int_q, pend_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d, pend_frac_q, pend_frac_d;
  logic              pend_valid_q, pend_valid_d;
  logic              os_tick_q, os_tick_d, bit_tick_q, bit_tick_d, cfg_ack_q, cfg_ack_d;
  logic              carry, acc_clr, acc_step;
  logic [DIV_W-1:0]  last;

  function automatic logic [DIV_W-1:0] clamp_int(input logic [DIV_W-1:0] v);
    return (v < DIV_W'(2)) ? DIV_W'(2) : v;
  endfunction

  baud_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .step  (acc_step),
    .frac  (act_frac_q),
    .carry (carry)
  );

  always_comb begin
    last         = act_int_q - DIV_W'(1) + DIV_W'(carry);
    cnt_d        = cnt_q;
    os_cnt_d     = os_cnt_q;
    act_int_d    = act_int_q;
    act_frac_d   = act_frac_q;
    pend_int_d   = pend_int_q;
    pend_frac_d  = pend_frac_q;
    pend_valid_d = pend_valid_q;
    os_tick_d    = 1'b0;
    bit_tick_d   = 1'b0;
    cfg_ack_d    = 1'b0;
    acc_clr      = 1'b0;
    acc_step     = 1'b0;

    if (load) begin
      pend_int_d   = clamp_int(div_int);
      pend_frac_d  = div_frac;
      pend_valid_d = 1'b1;
    end

    if (!en) begin
      cnt_d    = '0;
      os_cnt_d = '0;
      acc_clr  = 1'b1;
      if (pend_valid_q) begin
        act_int_d    = pend_int_q;
        act_frac_d   = pend_frac_q;
        pend_valid_d = load;
        cfg_ack_d    = 1'b1;
      end
    end else if (!en_q || sync_restart) begin
      // Period start: cnt=0 here means the tick lands on edge P from now.
      cnt_d   = '0;
      acc_clr = 1'b1;
      if (sync_restart) begin
        os_cnt_d = align_mid ? OsW'(OSR / 2) : '0;
        if (load) begin
          act_int_d    = clamp_int(div_int);
          act_frac_d   = div_frac;
          pend_valid_d = 1'b0;
          cfg_ack_d    = 1'b1;
        end
      end
    end else if (cnt_q == last) begin
      cnt_d      = '0;
      acc_step   = 1'b1;
      os_tick_d  = 1'b1;
      os_cnt_d   = os_cnt_q + OsW'(1);
      bit_tick_d = (os_cnt_q == OsW'(OSR - 1));
      if (pend_valid_q) begin
        act_int_d    = pend_int_q;
        act_frac_d   = pend_frac_q;
        pend_valid_d = load;
        cfg_ack_d    = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q         <= 1'b0;
      cnt_q        <= '0;
      os_cnt_q     <= '0;
      act_int_q    <= DIV_W'(DEF_DIV_INT);
      act_frac_q   <= FRAC_W'(DEF_DIV_FRAC);
      pend_int_q   <= DIV_W'(DEF_DIV_INT);
      pend_frac_q  <= FRAC_W'(DEF_DIV_FRAC);
      pend_valid_q <= 1'b0;
      os_tick_q    <= 1'b0;
      bit_tick_q   <= 1'b0;
      cfg_ack_q    <= 1'b0;
    end else begin
      en_q         <= en;
      cnt_q        <= cnt_d;
      os_cnt_q     <= os_cnt_d;
      act_int_q    <= act_int_d;
      act_frac_q   <= act_frac_d;
      pend_int_q   <= pend_int_d;
      pend_frac_q  <= pend_frac_d;
      pend_valid_q <= pend_valid_d;
      os_tick_q    <= os_tick_d;
      bit_tick_q   <= bit_tick_d;
      cfg_ack_q    <= cfg_ack_d;
    end
  end

  assign os_tick    = os_tick_q;
  assign bit_tick   = bit_tick_q;
  assign cfg_ack    = cfg_ack_q;
  assign active_div = {act_int_q, act_frac_q};

endmodule
